// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
// Bus bundle between the core and the integer register file.
//   A1, A2   : read addresses for rs1 / rs2
//   A3       : write address (rd)
//   WD3, WE3 : write data and write enable
//   RD1, RD2 : combinational read data
//   busy     : register file is resetting or clearing, core must hold off
//   wr_drop  : one-cycle pulse, a write arrived while busy and was discarded
// Modports: master = core side, slave = register file side.
// ---------------------------------------------------------------------------
interface regfile_param_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic            WE3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            busy;
  logic            wr_drop;

  modport master (
    output A1, A2, A3, WD3, WE3,
    input  RD1, RD2, busy, wr_drop
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3,
    output RD1, RD2, busy, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// Parametrised integer register file: two combinational read ports and one
// synchronous write port. After reset an init engine clears one entry per
// cycle and keeps busy high until every entry has been cleared.
//
// Parameters:
//   XLEN     : register / data width
//   NREGS    : number of registers (power of two, at least 4)
//   ZERO_REG : 1 -> register 0 reads as zero and ignores writes
//
// Ports:
//   CLK : core clock, rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_param_if.slave (addresses, write data/enable, read data,
//         busy, wr_drop)
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write data to a
// read port that addresses the register being written in the same cycle.
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             rst,
  regfile_param_if.slave   bus
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   init_idx_q, init_idx_d;
  logic            busy_q, busy_d;
  logic            wr_drop_q, wr_drop_d;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic            user_wr_ok;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // A user write is architecturally meaningful unless it targets the
  // hardwired zero register.
  assign user_wr_ok = bus.WE3 && !((ZERO_REG != 0) && (bus.A3 == '0));

  // Next-state logic: INIT walks init_idx across every entry and hands over
  // to RUN on the edge that clears the last one. Writes requested while in
  // INIT are reported through wr_drop on the following edge.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wr_drop_d  = 1'b0;
    case (state_q)
      INIT: begin
        wr_drop_d = bus.WE3;
        if (init_idx_q == AW'(NREGS - 1)) begin
          state_d    = RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d    = INIT;
        init_idx_d = '0;
      end
    endcase
    busy_d = (state_d == INIT);
  end

  // Control registers; busy is registered so it leaves INIT on the same
  // edge that the state does.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      busy_q     <= 1'b1;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      busy_q     <= busy_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Single write port shared by the init engine and the core. The rst term
  // discards anything sampled on an edge that coincides with reset.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_idx_q;
    wr_data = '0;
    if (state_q == INIT) begin
      wr_en = 1'b1;
    end else if (user_wr_ok) begin
      wr_en   = 1'b1;
      wr_addr = bus.A3;
      wr_data = bus.WD3;
    end
    if (rst) begin
      wr_en = 1'b0;
    end
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage array has no reset; the init engine is what clears it.
  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  // Read ports return zero until the clear is done so nothing undefined
  // ever reaches the core.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (state_q == RUN) begin
      if (!((ZERO_REG != 0) && (bus.A1 == '0))) begin
        rd1 = regs_q[bus.A1];
      end
      if (!((ZERO_REG != 0) && (bus.A2 == '0))) begin
        rd2 = regs_q[bus.A2];
      end
`ifdef REGFILE_BYPASS_EN
      if (user_wr_ok && (bus.A3 == bus.A1)) begin
        rd1 = bus.WD3;
      end
      if (user_wr_ok && (bus.A3 == bus.A2)) begin
        rd2 = bus.WD3;
      end
`else
      rd1 = rd1;
      rd2 = rd2;
`endif
    end
  end

  assign bus.RD1     = rd1;
  assign bus.RD2     = rd2;
  assign bus.busy    = busy_q;
  assign bus.wr_drop = wr_drop_q;

endmodule
